// File: rtl/bip_control.sv
// bip_control: multi-cycle FETCH/DECODE/EXEC sequencer for the BIP accumulator
// datapath. The state and the counters are registered on posedge. Outputs are
// decoded from the state register, so each strobe holds for a whole cycle and
// an asynchronous reset removes it at once.
module bip_control #(
  parameter int DB = 16,
  parameter int PB = 11
) (
  input  logic          clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [DB-1:0] Instr,
  output logic [PB-1:0] PC,
  output logic [PB-1:0] Addr,
  output logic [DB-1:0] Imm,
  output logic [1:0]    SelA,
  output logic          SelB,
  output logic          Op,
  output logic          WrAcc,
  output logic          Clear,
  output logic          RdRam,
  output logic          WrRam,
  output logic          Halted,
  output logic [15:0]   CycleCount
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT
  } state_t;

  typedef enum logic [4:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111,
    OP_CLR  = 5'b01000
  } opcode_t;

  state_t        state, state_next;
  logic [DB-1:0] ir;
  logic [PB-1:0] pc;
  logic [15:0]   cycles;
  opcode_t       opcode;
  logic          launch;
  logic          active;

  assign opcode     = opcode_t'(ir[DB-1:PB]);
  assign launch     = Start && ((state == S_IDLE) || (state == S_HALT));
  assign active     = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign PC         = pc;
  assign CycleCount = cycles;

  // State register
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Instruction register, loaded at the edge that ends FETCH
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n)               ir <= '0;
    else if (state == S_FETCH)  ir <= Instr;
  end

  // Program counter: cleared on launch, advanced at the end of EXEC, wraps freely
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n)             pc <= '0;
    else if (launch)          pc <= '0;
    else if (state == S_EXEC) pc <= pc + PB'(1);
  end

  // Executed-cycle counter, saturating, frozen outside FETCH/DECODE/EXEC
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n)                    cycles <= '0;
    else if (launch)                 cycles <= '0;
    else if (active && cycles != '1) cycles <= cycles + 16'd1;
  end

  // Next-state and output decode
  always_comb begin
    state_next = state;
    Addr       = '0;
    Imm        = '0;
    SelA       = 2'b00;
    SelB       = 1'b0;
    Op         = 1'b0;
    WrAcc      = 1'b0;
    Clear      = 1'b0;
    RdRam      = 1'b0;
    WrRam      = 1'b0;
    Halted     = 1'b0;

    case (state)
      S_IDLE:   if (Start) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = (opcode == OP_HLT) ? S_HALT : S_EXEC;
      S_EXEC:   state_next = S_FETCH;
      S_HALT: begin
        Halted = 1'b1;
        if (Start) state_next = S_FETCH;
      end
      default:  state_next = S_IDLE;
    endcase

    // Operand, selects and RAM read are set up in DECODE and held through EXEC;
    // the single strobe is asserted only in EXEC.
    if ((state == S_DECODE) || (state == S_EXEC)) begin
      Addr = ir[PB-1:0];
      Imm  = {{(DB-PB){ir[PB-1]}}, ir[PB-1:0]};
      case (opcode)
        OP_LD:   begin SelA = 2'b00; RdRam = 1'b1; end
        OP_LDI:  SelA = 2'b01;
        OP_ADD:  begin SelA = 2'b10; RdRam = 1'b1; end
        OP_ADDI: begin SelA = 2'b10; SelB = 1'b1; end
        OP_SUB:  begin SelA = 2'b10; RdRam = 1'b1; Op = 1'b1; end
        OP_SUBI: begin SelA = 2'b10; SelB = 1'b1; Op = 1'b1; end
        default: ;
      endcase
      if (state == S_EXEC) begin
        case (opcode)
          OP_STO:                                          WrRam = 1'b1;
          OP_LD, OP_LDI, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: WrAcc = 1'b1;
          OP_CLR:                                          Clear = 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bip_control.sv
// Bench for bip_control: an instruction-level model predicts every output on
// every cycle of a 16-bit instance; a PB = 3 instance is driven through a run of
// NOPs to exercise PC wrap.
module tb_bip_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] instr;
  logic [10:0] d_pc, d_addr;
  logic [15:0] d_imm, d_cnt;
  logic [1:0]  d_sela;
  logic        d_selb, d_op, d_wracc, d_clear, d_rdram, d_wrram, d_halted;

  logic        s_start = 1'b0;
  logic [7:0]  s_instr;
  logic [2:0]  s_pc, s_addr;
  logic [7:0]  s_imm;
  logic [15:0] s_cnt;
  logic [1:0]  s_sela;
  logic        s_selb, s_op, s_wracc, s_clear, s_rdram, s_wrram, s_halted;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  logic [15:0] rom [0:2047];

  always #5 clk = ~clk;

  assign instr   = rom[d_pc];
  assign s_instr = 8'hF8;

  bip_control #(.DB(16), .PB(11)) dut (
    .clk(clk), .Reset_n(rst_n), .Start(start), .Instr(instr),
    .PC(d_pc), .Addr(d_addr), .Imm(d_imm), .SelA(d_sela), .SelB(d_selb),
    .Op(d_op), .WrAcc(d_wracc), .Clear(d_clear), .RdRam(d_rdram),
    .WrRam(d_wrram), .Halted(d_halted), .CycleCount(d_cnt)
  );

  bip_control #(.DB(8), .PB(3)) dut_small (
    .clk(clk), .Reset_n(rst_n), .Start(s_start), .Instr(s_instr),
    .PC(s_pc), .Addr(s_addr), .Imm(s_imm), .SelA(s_sela), .SelB(s_selb),
    .Op(s_op), .WrAcc(s_wracc), .Clear(s_clear), .RdRam(s_rdram),
    .WrRam(s_wrram), .Halted(s_halted), .CycleCount(s_cnt)
  );

  logic [62:0] d_vec;
  assign d_vec = {d_pc, d_addr, d_imm, d_sela, d_selb, d_op, d_wracc, d_clear,
                  d_rdram, d_wrram, d_halted, d_cnt};

  // Instruction-level model: an instruction occupies steps 0..2 (HLT stops after step 1)
  bit          m_busy = 1'b0, m_halt = 1'b0;
  int          m_step = 0;
  int          m_cnt = 0;
  logic [10:0] m_pc = '0;
  logic [15:0] m_ir = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_halt = 1'b0; m_step = 0; m_cnt = 0; m_pc = '0; m_ir = '0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1; m_halt = 1'b0; m_step = 0; m_cnt = 0; m_pc = '0;
      end
    end else begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (m_step == 0) begin
        m_ir = rom[m_pc];
        m_step = 1;
      end else if (m_step == 1) begin
        if (m_ir[15:11] == 5'd0) begin
          m_busy = 1'b0; m_halt = 1'b1;
        end else m_step = 2;
      end else begin
        m_pc = m_pc + 11'd1;
        m_step = 0;
      end
    end
  end

  function automatic logic [62:0] model_vec();
    logic [10:0] addr; logic [15:0] imm; logic [1:0] sela;
    logic selb, op, wracc, clr, rd, wr;
    logic [4:0] opc;
    addr = '0; imm = '0; sela = 2'd0; selb = 0; op = 0; wracc = 0; clr = 0; rd = 0; wr = 0;
    opc = m_ir[15:11];
    if (m_busy && m_step > 0) begin
      addr = m_ir[10:0];
      imm  = {{5{m_ir[10]}}, m_ir[10:0]};
      case (opc)
        5'd1: wr = (m_step == 2);
        5'd2: begin rd = 1; wracc = (m_step == 2); end
        5'd3: begin sela = 2'd1; wracc = (m_step == 2); end
        5'd4: begin sela = 2'd2; rd = 1; wracc = (m_step == 2); end
        5'd5: begin sela = 2'd2; selb = 1; wracc = (m_step == 2); end
        5'd6: begin sela = 2'd2; rd = 1; op = 1; wracc = (m_step == 2); end
        5'd7: begin sela = 2'd2; selb = 1; op = 1; wracc = (m_step == 2); end
        5'd8: clr = (m_step == 2);
        default: ;
      endcase
    end
    return {m_pc, addr, imm, sela, selb, op, wracc, clr, rd, wr, m_halt, 16'(m_cnt)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobe history for pinning the model with literal expectations
  int          n_wracc = 0, n_clear = 0, n_wrram = 0;
  logic [1:0]  sela_at [0:63];
  logic        selb_at [0:63];
  logic        op_at   [0:63];
  logic [15:0] imm_at  [0:63];
  logic [10:0] wr_addr_at [0:63];

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      check("cycle", {1'b0, d_vec}, {1'b0, model_vec()});
      if (d_wracc) begin
        sela_at[n_wracc % 64] = d_sela; selb_at[n_wracc % 64] = d_selb;
        op_at[n_wracc % 64] = d_op; imm_at[n_wracc % 64] = d_imm;
        n_wracc++;
      end
      if (d_clear) n_clear++;
      if (d_wrram) begin wr_addr_at[n_wrram % 64] = d_addr; n_wrram++; end
    end
  end

  task automatic load(input logic [15:0] p0, p1, p2, p3);
    for (int unsigned i = 0; i < 2048; i++) rom[i] = 16'h0000;
    rom[0] = p0; rom[1] = p1; rom[2] = p2; rom[3] = p3;
  endtask

  // Called at a negedge: raise Start across exactly one posedge
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      if (d_halted) break;
      @(negedge clk);
    end
    check({name, "_halt_reached"}, 64'(d_halted), 64'd1);
  endtask

  int bw, bc, br;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t, limit 200000)", $time);
    $fatal(1);
  end

  initial begin
    load(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    check("reset_outputs", {1'b0, d_vec}, 64'd0);
    check("reset_small_pc", 64'(s_pc), 64'd0);
    #2 rst_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    // Reset mid-EXEC of an LDI
    load(16'h1809, 16'h0000, 16'h0000, 16'h0000);
    pulse_start();
    begin
      int k;
      for (k = 0; k < 10; k++) begin
        if (d_wracc) break;
        @(negedge clk);
      end
    end
    check("ldi_exec_reached", 64'(d_wracc), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {1'b0, d_vec}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // LDI 5, ADDI 3, STO 7, HLT
    load(16'h1805, 16'h2803, 16'h0807, 16'h0000);
    bw = n_wracc; bc = n_clear; br = n_wrram;
    pulse_start();
    wait_halt("prog1");
    check("prog1_wracc_count", 64'(n_wracc - bw), 64'd2);
    check("prog1_sela_first", 64'(sela_at[bw % 64]), 64'd1);
    check("prog1_sela_second", 64'(sela_at[(bw + 1) % 64]), 64'd2);
    check("prog1_selb_second", 64'(selb_at[(bw + 1) % 64]), 64'd1);
    check("prog1_wrram_count", 64'(n_wrram - br), 64'd1);
    check("prog1_wrram_addr", 64'(wr_addr_at[br % 64]), 64'd7);
    check("prog1_clear_count", 64'(n_clear - bc), 64'd0);
    check("prog1_pc", 64'(d_pc), 64'd3);
    check("prog1_cycles", 64'(d_cnt), 64'd11);

    // SUBI 0x7FF, HLT
    load(16'h3FFF, 16'h0000, 16'h0000, 16'h0000);
    bw = n_wracc;
    pulse_start();
    wait_halt("subi");
    check("subi_wracc_count", 64'(n_wracc - bw), 64'd1);
    check("subi_imm", 64'(imm_at[bw % 64]), 64'hFFFF);
    check("subi_op", 64'(op_at[bw % 64]), 64'd1);
    check("subi_selb", 64'(selb_at[bw % 64]), 64'd1);
    check("subi_sela", 64'(sela_at[bw % 64]), 64'd2);

    // CLR, NOP(11111), HLT
    load(16'h4000, 16'hF800, 16'h0000, 16'h0000);
    bw = n_wracc; bc = n_clear; br = n_wrram;
    pulse_start();
    wait_halt("clr");
    check("clr_clear_count", 64'(n_clear - bc), 64'd1);
    check("clr_wracc_count", 64'(n_wracc - bw), 64'd0);
    check("clr_wrram_count", 64'(n_wrram - br), 64'd0);
    check("clr_pc", 64'(d_pc), 64'd2);
    check("clr_cycles", 64'(d_cnt), 64'd8);

    // Start during DECODE is ignored; Start in HALT restarts from PC 0
    load(16'h1801, 16'h2802, 16'h0000, 16'h0000);
    pulse_start();          // now in FETCH
    @(negedge clk);         // now in DECODE
    pulse_start();          // Start seen only by the edge ending DECODE
    wait_halt("ignore");
    check("ignore_pc", 64'(d_pc), 64'd2);
    check("ignore_cycles", 64'(d_cnt), 64'd8);
    @(negedge clk);
    pulse_start();
    check("restart_pc", 64'(d_pc), 64'd0);
    check("restart_cycles", 64'(d_cnt), 64'd0);
    check("restart_halted", 64'(d_halted), 64'd0);
    check("restart_wrstate", {62'd0, d_rdram, d_wracc}, 64'd0);
    wait_halt("restart");
    check("restart_final_cycles", 64'(d_cnt), 64'd8);

    // PB = 3 instance: ten NOPs, PC wraps after 7
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("small_pc", 64'(s_pc), 64'(k % 8));
      check("small_cycles", 64'(s_cnt), 64'(3 * k));
      for (int j = 0; j < 3; j++) begin
        check("small_quiet", {48'd0, s_addr, s_imm, s_sela, s_selb, s_op, s_wracc,
                              s_clear, s_rdram, s_wrram, s_halted},
              64'd0);
        @(negedge clk);
      end
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
